// File: rtl/system_niosii_onchip_memory3_pkg.sv
// Shared constants and helpers for the dual-port on-chip memory.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package system_niosii_onchip_memory3_pkg;

  // Read latency in enabled edges, without and with the output register stage.
  localparam int RD_LAT_DIRECT = 1;
  localparam int RD_LAT_OUTREG = 2;

  // Number of byte lanes in a data word.
  function automatic int num_lanes(input int data_w);
    return data_w / 8;
  endfunction

  // Bypass merge for one byte lane: take the freshly written byte when the
  // lane was written on the same edge as the read, otherwise keep the old byte.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       take_new);
    return take_new ? new_b : old_b;
  endfunction

endpackage

// File: rtl/system_niosii_onchip_memory3_ram.sv
// Storage array: one byte-enable write port, two synchronous read ports.
// Latency: read data appears one enabled edge after the address is presented.
// Backpressure: none; en low freezes writes and both read registers.
//
// Ports:
//   clk, en                         clock and global enable
//   wr_en/wr_addr/wr_be/wr_dat      write port (byte-lane enables)
//   rd_a_addr/rd_a_dat              read port A (old data on same-edge write)
//   rd_b_addr/rd_b_dat              read port B (old data on same-edge write)
module system_niosii_onchip_memory3_ram
  import system_niosii_onchip_memory3_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 12,
  parameter     INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [DATA_W-1:0]     wr_dat,
  input  logic [ADDR_W-1:0]     rd_a_addr,
  output logic [DATA_W-1:0]     rd_a_dat,
  input  logic [ADDR_W-1:0]     rd_b_addr,
  output logic [DATA_W-1:0]     rd_b_dat
);

  localparam int LANES = num_lanes(DATA_W);

  // INIT_FILE is carried as a parameter so the memory compiler / synthesis
  // flow can attach it to the inferred array; the array has no reset.
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (wr_en) begin
        for (int l = 0; l < LANES; l++) begin
          if (wr_be[l]) mem[wr_addr][l*8 +: 8] <= wr_dat[l*8 +: 8];
        end
      end
      rd_a_dat <= mem[rd_a_addr];
      rd_b_dat <= mem[rd_b_addr];
    end
  end

endmodule

// File: rtl/system_niosii_onchip_memory3.sv
// Dual-port on-chip memory: port A read/write with byte enables, port B read-only.
// Latency: 1 enabled edge (OUT_REG=0) or 2 (OUT_REG=1), fully pipelined.
// Backpressure: none (no waitrequest); clken low or reset_req high freezes all state.
//
// Ports:
//   clk, reset_n (async, active-low), clken, reset_req
//   s1_*  port A: address, chipselect, read, write, byteenable, writedata,
//         readdata, readdatavalid
//   s2_*  port B: address, chipselect, read, readdata, readdatavalid
module system_niosii_onchip_memory3
  import system_niosii_onchip_memory3_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 12,
  parameter int OUT_REG   = 0,
  parameter     INIT_FILE = "system_NiosII_onchip_memory3.hex"
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  input  logic                  reset_req,
  input  logic [ADDR_W-1:0]     s1_address,
  input  logic                  s1_chipselect,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [DATA_W/8-1:0]   s1_byteenable,
  input  logic [DATA_W-1:0]     s1_writedata,
  output logic [DATA_W-1:0]     s1_readdata,
  output logic                  s1_readdatavalid,
  input  logic [ADDR_W-1:0]     s2_address,
  input  logic                  s2_chipselect,
  input  logic                  s2_read,
  output logic [DATA_W-1:0]     s2_readdata,
  output logic                  s2_readdatavalid
);

  localparam int LANES  = num_lanes(DATA_W);
  localparam int RD_LAT = (OUT_REG != 0) ? RD_LAT_OUTREG : RD_LAT_DIRECT;

  logic en;
  logic wr_acc, rd_a_acc, rd_b_acc;
  logic [DATA_W-1:0] ram_a_dat, ram_b_dat, b_s1_dat;
  logic a_last_vld, b_last_vld;
  logic [DATA_W-1:0] a_last_dat, b_last_dat;

  logic a_v1_q, a_v1_d, b_v1_q, b_v1_d;
  logic a_v2_q, a_v2_d, b_v2_q, b_v2_d;
  logic [DATA_W-1:0] a_d2_q, a_d2_d, b_d2_q, b_d2_d;
  logic [DATA_W-1:0] a_hold_q, a_hold_d, b_hold_q, b_hold_d;
  logic byp_hit_q, byp_hit_d;
  logic [DATA_W-1:0] byp_dat_q, byp_dat_d;
  logic [LANES-1:0]  byp_be_q, byp_be_d;

  assign en       = clken & ~reset_req;
  assign wr_acc   = en & s1_chipselect & s1_write;
  // A simultaneous read+write on port A is a write only.
  assign rd_a_acc = en & s1_chipselect & s1_read & ~s1_write;
  assign rd_b_acc = en & s2_chipselect & s2_read;

  system_niosii_onchip_memory3_ram #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk       (clk),
    .en        (en),
    .wr_en     (wr_acc),
    .wr_addr   (s1_address),
    .wr_be     (s1_byteenable),
    .wr_dat    (s1_writedata),
    .rd_a_addr (s1_address),
    .rd_a_dat  (ram_a_dat),
    .rd_b_addr (s2_address),
    .rd_b_dat  (ram_b_dat)
  );

  // The array returns the old word when port B reads the address port A
  // writes on the same edge; patch in the written lanes captured at that edge.
  always_comb begin
    b_s1_dat = ram_b_dat;
    for (int l = 0; l < LANES; l++) begin
      b_s1_dat[l*8 +: 8] = merge_byte(ram_b_dat[l*8 +: 8], byp_dat_q[l*8 +: 8],
                                      byp_hit_q & byp_be_q[l]);
    end
  end

  assign a_last_vld = (RD_LAT == RD_LAT_OUTREG) ? a_v2_q : a_v1_q;
  assign b_last_vld = (RD_LAT == RD_LAT_OUTREG) ? b_v2_q : b_v1_q;
  assign a_last_dat = (RD_LAT == RD_LAT_OUTREG) ? a_d2_q : ram_a_dat;
  assign b_last_dat = (RD_LAT == RD_LAT_OUTREG) ? b_d2_q : b_s1_dat;

  always_comb begin
    a_v1_d    = a_v1_q;
    b_v1_d    = b_v1_q;
    a_v2_d    = a_v2_q;
    b_v2_d    = b_v2_q;
    a_d2_d    = a_d2_q;
    b_d2_d    = b_d2_q;
    a_hold_d  = a_hold_q;
    b_hold_d  = b_hold_q;
    byp_hit_d = byp_hit_q;
    byp_dat_d = byp_dat_q;
    byp_be_d  = byp_be_q;
    if (en) begin
      a_v1_d    = rd_a_acc;
      b_v1_d    = rd_b_acc;
      a_v2_d    = a_v1_q;
      b_v2_d    = b_v1_q;
      a_d2_d    = ram_a_dat;
      b_d2_d    = b_s1_dat;
      byp_hit_d = wr_acc & rd_b_acc & (s1_address == s2_address);
      byp_dat_d = s1_writedata;
      byp_be_d  = s1_byteenable;
      // Remember the last presented word so readdata holds between valids.
      if (a_last_vld) a_hold_d = a_last_dat;
      if (b_last_vld) b_hold_d = b_last_dat;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_v1_q    <= 1'b0;
      b_v1_q    <= 1'b0;
      a_v2_q    <= 1'b0;
      b_v2_q    <= 1'b0;
      a_d2_q    <= '0;
      b_d2_q    <= '0;
      a_hold_q  <= '0;
      b_hold_q  <= '0;
      byp_hit_q <= 1'b0;
      byp_dat_q <= '0;
      byp_be_q  <= '0;
    end else begin
      a_v1_q    <= a_v1_d;
      b_v1_q    <= b_v1_d;
      a_v2_q    <= a_v2_d;
      b_v2_q    <= b_v2_d;
      a_d2_q    <= a_d2_d;
      b_d2_q    <= b_d2_d;
      a_hold_q  <= a_hold_d;
      b_hold_q  <= b_hold_d;
      byp_hit_q <= byp_hit_d;
      byp_dat_q <= byp_dat_d;
      byp_be_q  <= byp_be_d;
    end
  end

  // Valid is only presented in enabled cycles, so a frozen pipeline never
  // shows the same read twice; while frozen the held word is shown.
  assign s1_readdatavalid = a_last_vld & en;
  assign s2_readdatavalid = b_last_vld & en;
  assign s1_readdata      = s1_readdatavalid ? a_last_dat : a_hold_q;
  assign s2_readdata      = s2_readdatavalid ? b_last_dat : b_hold_q;

endmodule

// File: tb/tb_system_niosii_onchip_memory3.sv
module tb_system_niosii_onchip_memory3;

  logic        clk = 1'b0;
  logic        reset_n, clken, reset_req;
  logic [11:0] s1_address, s2_address;
  logic        s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read;
  logic [3:0]  s1_byteenable;
  logic [31:0] s1_writedata;
  logic [31:0] r1d0, r2d0, r1d1, r2d1;
  logic        r1v0, r2v0, r1v1, r2v1;

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl [4096];
  logic [31:0] qa0[$], qb0[$], qa1[$], qb1[$];
  logic [31:0] hold_exp;

  always #5 clk = ~clk;

  system_niosii_onchip_memory3 #(.DATA_W(32), .ADDR_W(12), .OUT_REG(0), .INIT_FILE("")) u0 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(r1d0), .s1_readdatavalid(r1v0),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_readdata(r2d0), .s2_readdatavalid(r2v0));

  system_niosii_onchip_memory3 #(.DATA_W(32), .ADDR_W(12), .OUT_REG(1), .INIT_FILE("")) u1 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(r1d1), .s1_readdatavalid(r1v1),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_readdata(r2d1), .s2_readdatavalid(r2v1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic idle();
    s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    s1_byteenable = 4'h0; s1_writedata = 32'h0; s1_address = 12'h0;
    s2_chipselect = 1'b0; s2_read = 1'b0; s2_address = 12'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drivers update the reference model / scoreboard as the request is driven.
  task automatic set_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = a;
    s1_writedata = d; s1_byteenable = be;
    for (int l = 0; l < 4; l++) if (be[l]) mdl[a][l*8 +: 8] = d[l*8 +: 8];
  endtask

  task automatic set_rda(input logic [11:0] a);
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = a;
    qa0.push_back(mdl[a]); qa1.push_back(mdl[a]);
  endtask

  task automatic set_rdb(input logic [11:0] a);
    s2_chipselect = 1'b1; s2_read = 1'b1; s2_address = a;
    qb0.push_back(mdl[a]); qb1.push_back(mdl[a]);
  endtask

  // Scoreboard: every presented valid pops one expected word.
  always @(negedge clk) begin
    if (reset_n) begin
      if (r1v0) begin
        if (qa0.size() == 0) chkb("spurious_a0", r1v0, 1'b0);
        else chk("mon_a0", r1d0, qa0.pop_front());
      end
      if (r2v0) begin
        if (qb0.size() == 0) chkb("spurious_b0", r2v0, 1'b0);
        else chk("mon_b0", r2d0, qb0.pop_front());
      end
      if (r1v1) begin
        if (qa1.size() == 0) chkb("spurious_a1", r1v1, 1'b0);
        else chk("mon_a1", r1d1, qa1.pop_front());
      end
      if (r2v1) begin
        if (qb1.size() == 0) chkb("spurious_b1", r2v1, 1'b0);
        else chk("mon_b1", r2d1, qb1.pop_front());
      end
    end
  end

  initial begin
    idle();
    reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0;
    repeat (2) tick();
    chkb("rst_v1_0", r1v0, 1'b0); chkb("rst_v2_0", r2v0, 1'b0);
    chkb("rst_v1_1", r1v1, 1'b0); chkb("rst_v2_1", r2v1, 1'b0);
    chk("rst_d1_0", r1d0, 32'h0); chk("rst_d2_1", r2d1, 32'h0);
    reset_n = 1'b1;
    tick();

    // Write then read port A.
    set_wr(12'd5, 32'hDEADBEEF, 4'hF); tick();
    idle(); set_rda(12'd5); tick(); idle();
    @(negedge clk);
    chkb("wr_rd_lat1_v0", r1v0, 1'b1); chkb("wr_rd_lat1_v1", r1v1, 1'b0);
    chk("wr_rd_dat0", r1d0, 32'hDEADBEEF);
    tick(); @(negedge clk);
    chkb("wr_rd_lat2_v1", r1v1, 1'b1); chkb("wr_rd_once_v0", r1v0, 1'b0);
    chk("wr_rd_dat1", r1d1, 32'hDEADBEEF);

    // Same-edge write on A and read on B of the same word.
    tick();
    set_wr(12'd5, 32'h11223344, 4'h5); set_rdb(12'd5); tick(); idle();
    @(negedge clk);
    chkb("byp_v0", r2v0, 1'b1); chk("byp_dat0", r2d0, 32'hDE22BE44);
    tick(); @(negedge clk);
    chk("byp_dat1", r2d1, 32'hDE22BE44);
    chkb("byp_hold_v0", r2v0, 1'b0); chk("byp_hold_d0", r2d0, 32'hDE22BE44);

    // Preload words 0..15.
    for (int i = 0; i < 16; i++) begin
      idle(); set_wr(12'(i), 32'hA0B0C0D0 + 32'(i) * 32'h01010101, 4'hF); tick();
    end

    // Back-to-back port A reads 0..3.
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i < 4) set_rda(12'(i));
      tick(); @(negedge clk);
      chkb($sformatf("b2b_v0_%0d", i), r1v0, (i <= 3));
      chkb($sformatf("b2b_v1_%0d", i), r1v1, (i >= 1 && i <= 4));
      #1;
    end

    // Read, then freeze for 3 edges.
    hold_exp = mdl[3];
    tick();
    idle(); set_rda(12'd2); tick();
    clken = 1'b0; idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chkb($sformatf("frz_v0_%0d", k), r1v0, 1'b0);
      chkb($sformatf("frz_v1_%0d", k), r1v1, 1'b0);
      chk($sformatf("frz_hold_%0d", k), r1d0, hold_exp);
      tick();
    end
    clken = 1'b1;
    @(negedge clk);
    chkb("res_v0", r1v0, 1'b1); chkb("res_v1_early", r1v1, 1'b0);
    tick(); @(negedge clk);
    chkb("res_v0_once", r1v0, 1'b0); chkb("res_v1", r1v1, 1'b1);
    tick(); @(negedge clk);
    chkb("res_v1_once", r1v1, 1'b0);

    // Reset between acceptance and valid.
    tick();
    idle(); set_rda(12'd6); set_rdb(12'd7); tick();
    reset_n = 1'b0; idle();
    qa0.delete(); qb0.delete(); qa1.delete(); qb1.delete();
    #1;
    chkb("arst_v1_0", r1v0, 1'b0); chkb("arst_v2_0", r2v0, 1'b0);
    chkb("arst_v1_1", r1v1, 1'b0); chkb("arst_v2_1", r2v1, 1'b0);
    chk("arst_d1_0", r1d0, 32'h0); chk("arst_d2_1", r2d1, 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chkb($sformatf("post_rst_v0_%0d", k), r1v0 | r2v0, 1'b0);
      chkb($sformatf("post_rst_v1_%0d", k), r1v1 | r2v1, 1'b0);
      tick();
    end
    set_rda(12'd5); set_rdb(12'd6); tick(); idle();
    repeat (3) tick();

    // Read and write together: write only.
    set_wr(12'd9, 32'hCAFEF00D, 4'hF); s1_read = 1'b1; tick(); idle();
    @(negedge clk); chkb("rw_v0", r1v0, 1'b0);
    tick(); @(negedge clk); chkb("rw_v1", r1v1, 1'b0);
    tick();
    set_rda(12'd9); tick(); idle();
    repeat (3) tick();

    // Random traffic on both ports with occasional reset_req freezes.
    for (int c = 0; c < 60; c++) begin
      idle();
      reset_req = ($urandom_range(0, 7) == 0);
      if (reset_req) begin
        s1_chipselect = 1'b1; s1_write = 1'b1; s1_byteenable = 4'hF;
        s1_address = 12'($urandom_range(0, 15)); s1_writedata = $urandom;
        s2_chipselect = 1'b1; s2_read = 1'b1; s2_address = 12'($urandom_range(0, 15));
      end else begin
        if ($urandom_range(0, 1) == 1)
          set_wr(12'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
        else if ($urandom_range(0, 1) == 1)
          set_rda(12'($urandom_range(0, 15)));
        if ($urandom_range(0, 1) == 1) set_rdb(12'($urandom_range(0, 15)));
      end
      tick();
    end
    reset_req = 1'b0; idle();
    repeat (4) tick();
    chk("drain_a0", qa0.size(), 0); chk("drain_b0", qb0.size(), 0);
    chk("drain_a1", qa1.size(), 0); chk("drain_b1", qb1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/system_niosii_onchip_memory3.md
SYSTEM_NIOSII_ONCHIP_MEMORY3 -- requirements
Module: system_NiosII_onchip_memory3

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits; legal values are multiples of 8.
REQ-002 SHALL have parameter ADDR_W, default 12, word address width; depth = 2**ADDR_W words.
REQ-003 SHALL have parameter OUT_REG, default 0; 0 = read latency 1, 1 = read latency 2.
REQ-004 SHALL have parameter INIT_FILE, default "system_NiosII_onchip_memory3.hex"; an empty string means initialise to all zeros.
REQ-005 SHALL have port clk  input  1  sole clock; all logic is rising-edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port clken  input  1  global clock enable; low freezes all state.
REQ-008 SHALL have port reset_req  input  1  high behaves as clken low.
REQ-009 SHALL have port s1_address  input  ADDR_W  port A word address.
REQ-010 SHALL have port s1_chipselect  input  1  port A select.
REQ-011 SHALL have port s1_read  input  1  port A read request.
REQ-012 SHALL have port s1_write  input  1  port A write request.
REQ-013 SHALL have port s1_byteenable  input  DATA_W/8  port A byte lanes.
REQ-014 SHALL have port s1_writedata  input  DATA_W  port A write data.
REQ-015 SHALL have port s1_readdata  output  DATA_W  port A read data.
REQ-016 SHALL have port s1_readdatavalid  output  1  port A read data qualifier.
REQ-017 SHALL have port s2_address  input  ADDR_W  port B (read-only) word address.
REQ-018 SHALL have port s2_chipselect  input  1  port B select.
REQ-019 SHALL have port s2_read  input  1  port B read request.
REQ-020 SHALL have port s2_readdata  output  DATA_W  port B read data.
REQ-021 SHALL have port s2_readdatavalid  output  1  port B read data qualifier.

Function
REQ-022 SHALL define en = clken & ~reset_req; when en is low, no memory write, pipeline advance, or output change shall occur.
REQ-023 SHALL perform a port A write on an edge with en & s1_chipselect & s1_write, updating only the bytes whose byteenable bit is 1.
REQ-024 SHALL accept a port A read on en & s1_chipselect & s1_read & ~s1_write; when read and write are both asserted, the write is performed and no read is issued.
REQ-025 SHALL accept a port B read on en & s2_chipselect & s2_read.
REQ-026 SHALL assert sN_readdatavalid for exactly one enabled cycle per accepted read, 1 (OUT_REG=0) or 2 (OUT_REG=1) enabled edges after acceptance, with matching sN_readdata.
REQ-027 SHALL accept back-to-back reads every enabled cycle on both ports with no waitrequest (fully pipelined, throughput 1).
REQ-028 SHALL hold sN_readdata at its last value when readdatavalid is low.
REQ-029 SHALL return new data on port B when it reads the address that port A writes on the same edge: enabled bytes from s1_writedata, all other bytes from the old word.
REQ-030 SHALL return, on a port A read, data that includes every write accepted on an earlier edge.
REQ-031 SHALL, while en is low, hold pending read pipeline stages and resume them unchanged when en returns high; valid stays high only for the cycle in which it was presented.

Reset
REQ-032 SHALL clear s1_readdatavalid, s2_readdatavalid and all internal valid stages immediately on reset_n low, independent of clk.
REQ-033 SHALL drive s1_readdata and s2_readdata to 0 during reset.
REQ-034 SHALL leave memory contents unchanged by reset; reads in flight at reset are discarded and never signalled.

Structure
REQ-035 SHALL place the latency constants (1 and 2), the byte-lane count function and the bypass-merge function in package system_NiosII_onchip_memory3_pkg.
REQ-036 SHALL instantiate exactly one storage sub-module, system_NiosII_onchip_memory3_ram, containing only an inferable simple dual-port RAM with byte-enable write and an unregistered 1-cycle read; valid pipelines, bypass and output registers stay in the top level.

Verification
REQ-037 SHALL cover this scenario: write 0xDEADBEEF to address 5 with byteenable=0xF, then read A address 5 -> s1_readdatavalid 1 cycle later (OUT_REG=0) with 0xDEADBEEF.
REQ-038 SHALL cover this scenario: address 5 holds 0xDEADBEEF; write 0x11223344 with byteenable=0x5 while port B reads address 5 on the same edge -> s2_readdata = 0xDE22BE44.
REQ-039 SHALL cover this scenario: with OUT_REG=1, port A reads addresses 0,1,2,3 on consecutive edges -> readdatavalid high on 4 consecutive cycles starting 2 cycles later, with data in order.
REQ-040 SHALL cover this scenario: issue a read, drop clken for 3 cycles, then raise it -> valid appears only after resumption with the correct data, with no duplicate or lost valid.
REQ-041 SHALL cover this scenario: assert reset_n low between a read acceptance and its valid -> valids are 0 immediately, no valid is issued afterwards, and data written before reset is still readable.
REQ-042 SHALL cover this scenario: assert s1_read and s1_write together at address 9 -> the word is written and s1_readdatavalid stays 0.
